// File: rtl/reloj_oci_trace_pkg.sv
// ---------------------------------------------------------------------------
// reloj_oci_trace_pkg
// Shared definitions for the OCI debug-trace atom packer.
//   ATOM_W     : width of one trace atom
//   DCT_ATOMS  : atoms per full compressed-trace frame
//   DCT_BUF_W  : packing buffer width (DCT_ATOMS * ATOM_W)
//   DCT_CNT_W  : width of the atom count field
//   FRAME_W    : width of an emitted frame {count, buffer}
//   dct_state_e: packer sequencing states
// ---------------------------------------------------------------------------
package reloj_oci_trace_pkg;

    localparam int ATOM_W    = 2;
    localparam int DCT_ATOMS = 15;
    localparam int DCT_BUF_W = 30;
    localparam int DCT_CNT_W = 4;
    localparam int FRAME_W   = DCT_CNT_W + DCT_BUF_W;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        ENDED = 2'd3
    } dct_state_e;

    // A frame carries the atom count above the packed buffer so the sink can
    // tell how many of the low-order atoms are meaningful.
    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [DCT_CNT_W-1:0] cnt,
        input logic [DCT_BUF_W-1:0] atoms
    );
        return {cnt, atoms};
    endfunction

endpackage

// File: rtl/reloj_oci_trace_outreg.sv
// ---------------------------------------------------------------------------
// reloj_oci_trace_outreg
// One-entry valid/ready holding register between the packer and the
// trace-frame sink.
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset
//   load_i  : capture data_i this edge (only asserted when free_o is high)
//   data_i  : frame to capture
//   ready_i : sink accepts the held frame when valid_o is high
//   valid_o : a frame is held
//   data_o  : held frame
//   free_o  : slot can take a new frame this edge (empty, or draining now)
// ---------------------------------------------------------------------------
module reloj_oci_trace_outreg
    import reloj_oci_trace_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               load_i,
    input  logic [FRAME_W-1:0] data_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [FRAME_W-1:0] data_o,
    output logic               free_o
);

    logic               valid_q, valid_d;
    logic [FRAME_W-1:0] data_q, data_d;

    // The slot is reusable in the same edge the sink takes the current frame,
    // which is what allows one frame per 15 cycles with no bubble.
    assign free_o  = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // A load wins over a handshake so back-to-back frames keep valid high;
    // the data is left in place after a handshake since valid qualifies it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/reloj_nios2_qsys_0_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// reloj_nios2_qsys_0_oci_dct_packer
// Packs the 2-bit OCI debug-trace atom stream into 30-bit compressed-trace
// frames, exposes the live packing state to the trace monitor, and sequences
// the end-of-test drain.
//   clk            : clock
//   reset_n        : asynchronous active-low reset
//   atom_valid/atom_data/atom_ready : atom input handshake
//   flush          : one-cycle request to emit a partial buffer
//   test_ending    : level request for the final drain
//   dct_buffer     : live packing buffer, newest atom in [1:0]
//   dct_count      : atoms currently held (0..15)
//   frame_valid/frame_data/frame_ready : frame output handshake
//   test_has_ended : sticky, set once the drain has completed
// Parameter IDLE_FLUSH: idle cycles before a partial buffer auto-flushes
// (0 disables).
// ---------------------------------------------------------------------------
module reloj_nios2_qsys_0_oci_dct_packer
    import reloj_oci_trace_pkg::*;
#(
    parameter int IDLE_FLUSH = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 atom_valid,
    input  logic [ATOM_W-1:0]    atom_data,
    output logic                 atom_ready,
    input  logic                 flush,
    input  logic                 test_ending,
    output logic [DCT_BUF_W-1:0] dct_buffer,
    output logic [DCT_CNT_W-1:0] dct_count,
    output logic                 frame_valid,
    output logic [FRAME_W-1:0]   frame_data,
    input  logic                 frame_ready,
    output logic                 test_has_ended
);

    localparam logic [7:0] IDLE_LIM = 8'(IDLE_FLUSH);

    dct_state_e           state_q, state_d;
    logic                 atom_ready_q;
    logic                 ended_q;
    logic [DCT_BUF_W-1:0] pack_q, pack_d, pack_acc;
    logic [DCT_CNT_W-1:0] cnt_q, cnt_d, cnt_acc;
    logic                 pend_q, pend_d;
    logic [7:0]           idle_q, idle_d;

    logic accept;
    logic slot_free;
    logic idle_expire;
    logic flush_req;
    logic emit;
    logic transfer;

    assign atom_ready     = atom_ready_q;
    assign test_has_ended = ended_q;
    assign dct_buffer     = pack_q;
    assign dct_count      = cnt_q;

    // Buffer and count as they stand after this edge's atom, so a frame
    // emitted on the same edge already contains that atom.
    assign accept   = atom_valid & atom_ready_q;
    assign pack_acc = accept ? {pack_q[DCT_BUF_W-ATOM_W-1:0], atom_data} : pack_q;
    assign cnt_acc  = cnt_q + DCT_CNT_W'(accept);

    assign idle_expire = (IDLE_FLUSH != 0) && (cnt_q != '0) && (idle_q == IDLE_LIM);
    assign flush_req   = flush | pend_q | idle_expire;

    // Never emit an empty frame, whatever requested it.
    assign emit = (cnt_acc != '0) &&
                  ((cnt_acc == DCT_CNT_W'(DCT_ATOMS)) || flush_req || (state_q == DRAIN));
    assign transfer = emit & slot_free;

    reloj_oci_trace_outreg u_outreg (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .load_i  (transfer),
        .data_i  (pack_frame(cnt_acc, pack_acc)),
        .ready_i (frame_ready),
        .valid_o (frame_valid),
        .data_o  (frame_data),
        .free_o  (slot_free)
    );

    // Packing buffer, pending-flush bit and idle timer. A flush that cannot
    // be serviced because the slot is busy collapses into one pending bit;
    // the idle timer restarts on every accepted atom and every transfer and
    // saturates at its limit so the expiry stays asserted until serviced.
    always_comb begin
        pack_d = pack_acc;
        cnt_d  = cnt_acc;
        pend_d = pend_q | ((flush | idle_expire) & (cnt_acc != '0));
        idle_d = idle_q;
        if (transfer) begin
            pack_d = '0;
            cnt_d  = '0;
            pend_d = 1'b0;
        end
        if (accept | transfer) begin
            idle_d = '0;
        end else if ((cnt_q != '0) && (idle_q != IDLE_LIM)) begin
            idle_d = idle_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pack_q <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            idle_q <= '0;
        end else begin
            pack_q <= pack_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            idle_q <= idle_d;
        end
    end

    // Sequencing. FILL stalls into HOLD when a frame is due but the slot is
    // busy. A test ending with nothing buffered or in flight goes straight to
    // ENDED so the monitor hears about it one cycle later; otherwise DRAIN
    // emits the residue and waits for the slot to empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (test_ending) begin
                    if ((cnt_acc == '0) && !frame_valid) begin
                        state_d = ENDED;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (emit && !slot_free) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (transfer) begin
                    state_d = test_ending ? DRAIN : FILL;
                end
            end
            DRAIN: begin
                if ((cnt_q == '0) && !frame_valid) begin
                    state_d = ENDED;
                end
            end
            ENDED: state_d = ENDED;
            default: state_d = FILL;
        endcase
    end

    // State plus its registered decodes; atom_ready therefore has no
    // combinational dependence on frame_ready. Held low during reset so no
    // atom is taken until the packer has come out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FILL;
            atom_ready_q <= 1'b0;
            ended_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            atom_ready_q <= (state_d == FILL);
            ended_q      <= (state_d == ENDED);
        end
    end

endmodule

// File: tb/tb_reloj_nios2_qsys_0_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// tb_reloj_nios2_qsys_0_oci_dct_packer
// Self-checking bench for the OCI trace atom packer (IDLE_FLUSH = 4).
// Expected frames go into a queue as stimulus is driven; a monitor pops
// them as the sink handshakes frames out of the DUT.
// ---------------------------------------------------------------------------
module tb_reloj_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        resetN;
    logic        atomValid;
    logic [1:0]  atomData;
    logic        atomReady;
    logic        flushIn;
    logic        testEnding;
    logic [29:0] dctBuffer;
    logic [3:0]  dctCount;
    logic        frameValid;
    logic [33:0] frameData;
    logic        frameReady;
    logic        testHasEnded;

    int nvec = 0;
    int nmis = 0;
    logic [33:0] expQ[$];

    typedef struct {
        int          n;
        logic [29:0] atoms;
        int          fmode;
        bit          expValid;
        logic [33:0] expFrame;
    } vecT;

    vecT vecs[8];

    always #5 clk = ~clk;

    reloj_nios2_qsys_0_oci_dct_packer #(.IDLE_FLUSH(4)) dut (
        .clk            (clk),
        .reset_n        (resetN),
        .atom_valid     (atomValid),
        .atom_data      (atomData),
        .atom_ready     (atomReady),
        .flush          (flushIn),
        .test_ending    (testEnding),
        .dct_buffer     (dctBuffer),
        .dct_count      (dctCount),
        .frame_valid    (frameValid),
        .frame_data     (frameData),
        .frame_ready    (frameReady),
        .test_has_ended (testHasEnded)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nvec++;
        if (actual !== expected) begin
            nmis++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Inputs are driven on the falling edge and held across the next rising
    // edge; the task returns on the following falling edge.
    task automatic applyStimulus(input logic v, input logic [1:0] a, input logic f);
        atomValid = v;
        atomData  = a;
        flushIn   = f;
        @(negedge clk);
        atomValid = 1'b0;
        atomData  = 2'b00;
        flushIn   = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int k = 0;
        while (expQ.size() != 0 && k < 8) begin
            applyStimulus(1'b0, 2'b00, 1'b0);
            k++;
        end
        nvec++;
        if (expQ.size() != 0) begin
            nmis++;
            $display("[TB] FAIL %s: %0d frames outstanding, expected 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    // Sink-side monitor: a frame is taken on the rising edge that follows a
    // falling edge where valid and ready are both high.
    always begin
        logic [33:0] expFrame;
        @(negedge clk);
        #1;
        if (resetN && frameValid && frameReady) begin
            nvec++;
            if (expQ.size() == 0) begin
                nmis++;
                $display("[TB] FAIL unexpectedFrame: got %0h, expected none", frameData);
            end else begin
                expFrame = expQ.pop_front();
                if (frameData !== expFrame) begin
                    nmis++;
                    $display("[TB] FAIL frameData: got %0h, expected %0h", frameData, expFrame);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [29:0] sh;
        logic [33:0] f1;
        logic [33:0] f2;
        logic [1:0]  a;
        int          acc;
        int          k;

        vecs[0] = '{15, 30'b011011011011011011011011011011, 0, 1'b1,
                    {4'd15, 30'b011011011011011011011011011011}};
        vecs[1] = '{3, 30'b011011, 2, 1'b1, {4'd3, 24'b0, 6'b011011}};
        vecs[2] = '{0, 30'b0, 2, 1'b0, 34'b0};
        vecs[3] = '{3, 30'b110010, 1, 1'b1, {4'd3, 24'b0, 6'b110010}};
        vecs[4] = '{1, 30'b10, 1, 1'b1, {4'd1, 30'h2}};
        vecs[5] = '{14, 30'h0FFFFFFF, 2, 1'b1, {4'd14, 30'h0FFFFFFF}};
        vecs[6] = '{5, 30'h1, 1, 1'b1, {4'd5, 30'h1}};
        vecs[7] = '{15, 30'h2AAAAAAA, 1, 1'b1, {4'd15, 30'h2AAAAAAA}};

        resetN = 1'b0; atomValid = 1'b0; atomData = 2'b00; flushIn = 1'b0;
        testEnding = 1'b0; frameReady = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("resetBuffer", 64'(dctBuffer), 64'd0);
        checkOutput("resetCount", 64'(dctCount), 64'd0);
        checkOutput("resetFrameValid", 64'(frameValid), 64'd0);
        checkOutput("resetFrameData", 64'(frameData), 64'd0);
        checkOutput("resetEnded", 64'(testHasEnded), 64'd0);
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("readyAfterReset", 64'(atomReady), 64'd1);

        // Table of bursts with the sink always ready.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].expValid) expQ.push_back(vecs[i].expFrame);
            for (int j = 0; j < vecs[i].n; j++) begin
                applyStimulus(1'b1, vecs[i].atoms[2*(vecs[i].n-1-j) +: 2],
                              (vecs[i].fmode == 1) && (j == vecs[i].n - 1));
            end
            if (vecs[i].fmode == 2) applyStimulus(1'b0, 2'b00, 1'b1);
            if (vecs[i].expValid) begin
                waitDrain("vectorFrame");
            end else begin
                repeat (3) applyStimulus(1'b0, 2'b00, 1'b0);
                checkOutput("noEmptyFrame", 64'(frameValid), 64'd0);
            end
            checkOutput("countClearedAfterVector", 64'(dctCount), 64'd0);
        end

        // Sink stalled while 30 atoms are offered.
        frameReady = 1'b0;
        acc = 0; sh = '0; f1 = '0; f2 = '0;
        for (int c = 0; c < 60 && acc < 30; c++) begin
            a = (acc < 15) ? 2'((acc % 3) + 1) : 2'(acc % 4);
            if (atomReady) begin
                sh = {sh[27:0], a};
                acc++;
                if (acc == 15) begin f1 = {4'd15, sh}; expQ.push_back(f1); sh = '0; end
                if (acc == 30) begin f2 = {4'd15, sh}; expQ.push_back(f2); end
            end
            applyStimulus(1'b1, a, 1'b0);
        end
        checkOutput("stallAccepted", 64'(acc), 64'd30);
        checkOutput("stallReadyLow", 64'(atomReady), 64'd0);
        checkOutput("stallCount", 64'(dctCount), 64'd15);
        checkOutput("stallHeldValid", 64'(frameValid), 64'd1);
        checkOutput("stallHeldData", 64'(frameData), 64'(f1));
        repeat (2) begin
            applyStimulus(1'b1, 2'b11, 1'b0);
            checkOutput("stallRefuses", 64'(atomReady), 64'd0);
            checkOutput("stallCountHeld", 64'(dctCount), 64'd15);
        end
        frameReady = 1'b1;
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("resumeReady", 64'(atomReady), 64'd1);
        checkOutput("resumeCount", 64'(dctCount), 64'd0);
        checkOutput("resumeSecondFrame", 64'(frameValid), 64'd1);
        waitDrain("stallFrames");

        // Idle auto-flush of a two-atom buffer.
        expQ.push_back({4'd2, 26'b0, 4'b1101});
        applyStimulus(1'b1, 2'b11, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(1'b0, 2'b00, 1'b0);
            checkOutput("idleFrameValid", 64'(frameValid), (c == 5) ? 64'd1 : 64'd0);
        end
        waitDrain("idleFrame");

        // Seven atoms then end of test.
        sh = '0;
        for (int j = 0; j < 7; j++) sh = {sh[27:0], 2'(j % 4)};
        expQ.push_back({4'd7, sh});
        for (int j = 0; j < 7; j++) applyStimulus(1'b1, 2'(j % 4), 1'b0);
        testEnding = 1'b1;
        k = 0;
        while (frameValid !== 1'b1 && k < 6) begin
            applyStimulus(1'b0, 2'b00, 1'b0);
            k++;
        end
        checkOutput("drainFrameValid", 64'(frameValid), 64'd1);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("endedBeforeLatency", 64'(testHasEnded), 64'd0);
        checkOutput("drainHandshakeDone", 64'(frameValid), 64'd0);
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("endedAfterHandshake", 64'(testHasEnded), 64'd1);
        repeat (3) begin
            applyStimulus(1'b1, 2'b11, 1'b0);
            checkOutput("endedRefuses", 64'(atomReady), 64'd0);
            checkOutput("endedCount", 64'(dctCount), 64'd0);
        end
        waitDrain("drainFrame");
        testEnding = 1'b0;

        // Fresh start, then an asynchronous reset while stalled in HOLD.
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        frameReady = 1'b0;
        for (int j = 0; j < 15; j++) applyStimulus(1'b1, 2'b01, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b1);
        checkOutput("holdReadyLow", 64'(atomReady), 64'd0);
        checkOutput("holdCount", 64'(dctCount), 64'd3);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("asyncBuffer", 64'(dctBuffer), 64'd0);
        checkOutput("asyncCount", 64'(dctCount), 64'd0);
        checkOutput("asyncFrameValid", 64'(frameValid), 64'd0);
        checkOutput("asyncFrameData", 64'(frameData), 64'd0);
        checkOutput("asyncEnded", 64'(testHasEnded), 64'd0);
        checkOutput("asyncReady", 64'(atomReady), 64'd0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        frameReady = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("postResetReady", 64'(atomReady), 64'd1);
        checkOutput("postResetValid", 64'(frameValid), 64'd0);
        expQ.push_back({4'd1, 30'h3});
        applyStimulus(1'b1, 2'b11, 1'b1);
        waitDrain("postResetFrame");

        // End of test with nothing buffered.
        testEnding = 1'b1;
        applyStimulus(1'b0, 2'b00, 1'b0);
        checkOutput("emptyEndLatency", 64'(testHasEnded), 64'd1);
        testEnding = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
